// File: rtl/multicycle_control_if.sv
// Control bus between the multicycle RV32I control FSM (master) and its datapath (slave).
interface multicycle_control_if #(
  parameter int CONTROL_WIDTH = 3,
  parameter int OP_WIDTH      = 7
);
  logic [OP_WIDTH-1:0]      op;
  logic [2:0]               funct3;
  logic                     funct7b5;
  logic                     EQ;
  logic                     PCWrite;
  logic                     AdrSrc;
  logic                     MemWrite;
  logic                     IRWrite;
  logic [1:0]               ResultSrc;
  logic [1:0]               ALUSrcA;
  logic [1:0]               ALUSrcB;
  logic [2:0]               ImmSrc;
  logic [CONTROL_WIDTH-1:0] ALUControl;
  logic                     RegWrite;
  logic                     Retire;
  logic                     Illegal;

  modport master (
    input  op, funct3, funct7b5, EQ,
    output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ImmSrc, ALUControl, RegWrite, Retire, Illegal
  );

  modport slave (
    output op, funct3, funct7b5, EQ,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ImmSrc, ALUControl, RegWrite, Retire, Illegal
  );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle RV32I control FSM (lw/sw, R/I ALU ops, beq/bne, jal).
// ILLEGAL_TRAP_EN: when defined, an illegal decode parks the FSM in HALT until reset.
module multicycle_control #(
  parameter int CONTROL_WIDTH = 3,
  parameter int OP_WIDTH      = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  multicycle_control_if.master ctl
);
  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECR    = 4'd6;
  localparam logic [3:0] S_EXECI    = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;
  localparam logic [3:0] S_JAL      = 4'd10;
`ifdef ILLEGAL_TRAP_EN
  localparam logic [3:0] S_HALT     = 4'd11;
`endif

  localparam logic [CONTROL_WIDTH-1:0] ALU_ADD = CONTROL_WIDTH'(3'b000);
  localparam logic [CONTROL_WIDTH-1:0] ALU_SUB = CONTROL_WIDTH'(3'b001);
  localparam logic [CONTROL_WIDTH-1:0] ALU_AND = CONTROL_WIDTH'(3'b010);
  localparam logic [CONTROL_WIDTH-1:0] ALU_OR  = CONTROL_WIDTH'(3'b011);
  localparam logic [CONTROL_WIDTH-1:0] ALU_XOR = CONTROL_WIDTH'(3'b100);

  localparam logic [OP_WIDTH-1:0] OP_LOAD  = OP_WIDTH'(7'b0000011);
  localparam logic [OP_WIDTH-1:0] OP_STORE = OP_WIDTH'(7'b0100011);
  localparam logic [OP_WIDTH-1:0] OP_R     = OP_WIDTH'(7'b0110011);
  localparam logic [OP_WIDTH-1:0] OP_I     = OP_WIDTH'(7'b0010011);
  localparam logic [OP_WIDTH-1:0] OP_BR    = OP_WIDTH'(7'b1100011);
  localparam logic [OP_WIDTH-1:0] OP_JAL   = OP_WIDTH'(7'b1101111);

  logic [3:0]               state_q, state_d;
  logic                     pcw, adr, mw, irw, rw, ret, ill, legal;
  logic [1:0]               rs, sa, sb;
  logic [2:0]               imm;
  logic [CONTROL_WIDTH-1:0] alu;

  function automatic logic alu_f3_ok(input logic [2:0] f3);
    return (f3 == 3'b000) || (f3 == 3'b100) || (f3 == 3'b110) || (f3 == 3'b111);
  endfunction

  function automatic logic [CONTROL_WIDTH-1:0] alu_dec(input logic [2:0] f3, input logic sub);
    case (f3)
      3'b100:  return ALU_XOR;
      3'b110:  return ALU_OR;
      3'b111:  return ALU_AND;
      default: return sub ? ALU_SUB : ALU_ADD;
    endcase
  endfunction

  always_comb begin
    legal = 1'b0;
    case (ctl.op)
      OP_LOAD, OP_STORE: legal = (ctl.funct3 == 3'b010);
      OP_R:   legal = alu_f3_ok(ctl.funct3) && (!ctl.funct7b5 || ctl.funct3 == 3'b000);
      OP_I:   legal = alu_f3_ok(ctl.funct3);
      OP_BR:  legal = (ctl.funct3 == 3'b000) || (ctl.funct3 == 3'b001);
      OP_JAL: legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    case (ctl.op)
      OP_STORE: imm = 3'b001;
      OP_BR:    imm = 3'b010;
      OP_JAL:   imm = 3'b011;
      default:  imm = 3'b000;
    endcase
  end

  always_comb begin
    state_d = S_FETCH;
    pcw = 1'b0; adr = 1'b0; mw = 1'b0; irw = 1'b0;
    rw  = 1'b0; ret = 1'b0; ill = 1'b0;
    rs  = 2'b00; sa = 2'b00; sb = 2'b00;
    alu = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        irw = 1'b1; pcw = 1'b1; sb = 2'b10; rs = 2'b10;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        sa = 2'b01; sb = 2'b01;
        if (!legal) begin
          ill = 1'b1;
`ifdef ILLEGAL_TRAP_EN
          state_d = S_HALT;
`else
          state_d = S_FETCH;
`endif
        end else begin
          case (ctl.op)
            OP_R:    state_d = S_EXECR;
            OP_I:    state_d = S_EXECI;
            OP_BR:   state_d = S_BRANCH;
            OP_JAL:  state_d = S_JAL;
            default: state_d = S_MEMADR;
          endcase
        end
      end
      S_MEMADR: begin
        sa = 2'b10; sb = 2'b01;
        state_d = (ctl.op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adr = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        rs = 2'b01; rw = 1'b1; ret = 1'b1;
      end
      S_MEMWRITE: begin
        adr = 1'b1; mw = 1'b1; ret = 1'b1;
      end
      S_EXECR: begin
        sa = 2'b10; alu = alu_dec(ctl.funct3, ctl.funct7b5);
        state_d = S_ALUWB;
      end
      S_EXECI: begin
        sa = 2'b10; sb = 2'b01; alu = alu_dec(ctl.funct3, 1'b0);
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        rw = 1'b1; ret = 1'b1;
      end
      S_BRANCH: begin
        sa = 2'b10; alu = ALU_SUB; ret = 1'b1;
        pcw = ctl.funct3[0] ? ~ctl.EQ : ctl.EQ;
      end
      S_JAL: begin
        sa = 2'b01; sb = 2'b10; pcw = 1'b1;
        state_d = S_ALUWB;
      end
`ifdef ILLEGAL_TRAP_EN
      S_HALT: begin
        ill = 1'b1;
        state_d = S_HALT;
      end
`endif
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // Enables are gated by reset so an abandoned instruction can never write.
  assign ctl.PCWrite    = pcw & ~rst;
  assign ctl.MemWrite   = mw  & ~rst;
  assign ctl.IRWrite    = irw & ~rst;
  assign ctl.RegWrite   = rw  & ~rst;
  assign ctl.Retire     = ret & ~rst;
  assign ctl.Illegal    = ill & ~rst;
  assign ctl.AdrSrc     = adr;
  assign ctl.ResultSrc  = rs;
  assign ctl.ALUSrcA    = sa;
  assign ctl.ALUSrcB    = sb;
  assign ctl.ImmSrc     = imm;
  assign ctl.ALUControl = alu;
endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control; outputs sampled on the falling edge.
module tb_multicycle_control;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  multicycle_control_if #(.CONTROL_WIDTH(3), .OP_WIDTH(7)) bus ();

  multicycle_control #(.CONTROL_WIDTH(3), .OP_WIDTH(7)) dut (
    .clk (clk),
    .rst (rst),
    .ctl (bus)
  );

  always #5 clk = ~clk;

  logic [18:0] obs;
  logic [5:0]  en;
  assign obs = {bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.ResultSrc,
                bus.ALUSrcA, bus.ALUSrcB, bus.ImmSrc, bus.ALUControl,
                bus.RegWrite, bus.Retire, bus.Illegal};
  assign en  = {bus.PCWrite, bus.MemWrite, bus.IRWrite, bus.RegWrite, bus.Retire, bus.Illegal};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %05h expected %05h", tag, got, exp);
    end
  endtask

  // Field order: PCWrite AdrSrc MemWrite IRWrite ResultSrc ALUSrcA ALUSrcB ImmSrc ALUControl RegWrite Retire Illegal
  function automatic logic [18:0] ev(int pcw, int adr, int mw, int irw, int rs, int sa, int sb,
                                     int imm, int alu, int rw, int ret, int ill);
    return {pcw[0], adr[0], mw[0], irw[0], rs[1:0], sa[1:0], sb[1:0],
            imm[2:0], alu[2:0], rw[0], ret[0], ill[0]};
  endfunction

  task automatic cyc(input string tag, input logic [18:0] e);
    @(negedge clk);
    check(tag, 32'(obs), 32'(e));
  endtask

  task automatic set(input logic [6:0] op, input logic [2:0] f3, input logic f7, input logic eq);
    bus.op = op; bus.funct3 = f3; bus.funct7b5 = f7; bus.EQ = eq;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) begin
      @(negedge clk);
      check("reset_enables", 32'(en), 32'd0);
    end
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic fetch_decode(input string tag, input int imm, input int ill);
    cyc({tag, "_fetch"},  ev(1,0,0,1,2,0,2,imm,0,0,0,0));
    cyc({tag, "_decode"}, ev(0,0,0,0,0,1,1,imm,0,0,0,ill));
  endtask

  task automatic alu_op(input string tag, input logic [6:0] op, input logic [2:0] f3,
                        input logic f7, input int alu);
    set(op, f3, f7, 1'b0);
    fetch_decode(tag, 0, 0);
    if (op == 7'b0110011) cyc({tag, "_execr"}, ev(0,0,0,0,0,2,0,0,alu,0,0,0));
    else                  cyc({tag, "_execi"}, ev(0,0,0,0,0,2,1,0,alu,0,0,0));
    cyc({tag, "_aluwb"}, ev(0,0,0,0,0,0,0,0,0,1,1,0));
  endtask

  task automatic branch(input string tag, input logic [2:0] f3, input logic eq, input int pcw);
    set(7'b1100011, f3, 1'b0, eq);
    fetch_decode(tag, 2, 0);
    cyc({tag, "_branch"}, ev(pcw,0,0,0,0,2,0,2,1,0,1,0));
  endtask

  task automatic illegal(input string tag, input logic [6:0] op, input logic [2:0] f3,
                         input logic f7, input int imm);
    set(op, f3, f7, 1'b0);
    fetch_decode(tag, imm, 1);
`ifdef ILLEGAL_TRAP_EN
    repeat (10) cyc({tag, "_halt"}, ev(0,0,0,0,0,0,0,imm,0,0,0,1));
`else
    cyc({tag, "_next_fetch"}, ev(1,0,0,1,2,0,2,imm,0,0,0,0));
`endif
    do_reset(1);
  endtask

  initial begin
    set(7'b0110011, 3'b000, 1'b0, 1'b0);
    do_reset(3);

    // R-type sub, then the next FETCH confirms the 4-cycle length
    alu_op("sub",  7'b0110011, 3'b000, 1'b1, 1);
    alu_op("add",  7'b0110011, 3'b000, 1'b0, 0);
    alu_op("xor",  7'b0110011, 3'b100, 1'b0, 4);
    alu_op("and",  7'b0110011, 3'b111, 1'b0, 2);
    alu_op("addi_f7", 7'b0010011, 3'b000, 1'b1, 0);
    alu_op("ori",  7'b0010011, 3'b110, 1'b0, 3);

    set(7'b0000011, 3'b010, 1'b0, 1'b0);
    fetch_decode("lw", 0, 0);
    cyc("lw_memadr",  ev(0,0,0,0,0,2,1,0,0,0,0,0));
    cyc("lw_memread", ev(0,1,0,0,0,0,0,0,0,0,0,0));
    cyc("lw_memwb",   ev(0,0,0,0,1,0,0,0,0,1,1,0));

    set(7'b0100011, 3'b010, 1'b0, 1'b0);
    fetch_decode("sw", 1, 0);
    cyc("sw_memadr",   ev(0,0,0,0,0,2,1,1,0,0,0,0));
    cyc("sw_memwrite", ev(0,1,1,0,0,0,0,1,0,0,1,0));

    branch("beq_t",  3'b000, 1'b1, 1);
    branch("beq_nt", 3'b000, 1'b0, 0);
    branch("bne_t",  3'b001, 1'b0, 1);
    branch("bne_nt", 3'b001, 1'b1, 0);

    set(7'b1101111, 3'b000, 1'b0, 1'b0);
    fetch_decode("jal", 3, 0);
    cyc("jal_jal",   ev(1,0,0,0,0,1,2,3,0,0,0,0));
    cyc("jal_aluwb", ev(0,0,0,0,0,0,0,3,0,1,1,0));

    // reset while a load is mid-flight: MEMREAD/MEMWB must never appear
    set(7'b0000011, 3'b010, 1'b0, 1'b0);
    fetch_decode("lw_abort", 0, 0);
    cyc("lw_abort_memadr", ev(0,0,0,0,0,2,1,0,0,0,0,0));
    do_reset(2);

    set(7'b0110011, 3'b000, 1'b0, 1'b0);
    alu_op("post_rst_add", 7'b0110011, 3'b000, 1'b0, 0);

    illegal("ill_r001",  7'b0110011, 3'b001, 1'b0, 0);
    illegal("ill_r_f7",  7'b0110011, 3'b100, 1'b1, 0);
    illegal("ill_lw000", 7'b0000011, 3'b000, 1'b0, 0);
    illegal("ill_br100", 7'b1100011, 3'b100, 1'b0, 2);
    illegal("ill_op",    7'b0000000, 3'b000, 1'b0, 0);

    set(7'b0010011, 3'b111, 1'b0, 1'b0);
    alu_op("andi", 7'b0010011, 3'b111, 1'b0, 2);
    cyc("final_fetch", ev(1,0,0,1,2,0,2,0,0,0,0,0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Multicycle RV32I control FSM that drives the execute-stage ALU. It issues ALUControl and the SrcA/SrcB select codes, and consumes the ALU's EQ flag to resolve branches. It also sequences fetch, memory access and writeback enables for the shared-memory multicycle datapath. Supported subset: lw, sw, add/sub/and/or/xor (R type), addi/andi/ori/xori, beq/bne, jal.

Parameters:
CONTROL_WIDTH, 3, ALUControl width. Encoding: ADD=000, SUB=001, AND=010, OR=011, XOR=100.
OP_WIDTH, 7, opcode field width.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
op  input  OP_WIDTH  instruction[6:0], taken from the instruction register
funct3  input  3  instruction[14:12]
funct7b5  input  1  instruction[30]
EQ  input  1  ALU equality flag (SrcA==SrcB)
PCWrite  output  1  PC register enable
AdrSrc  output  1  memory address select: 0=PC, 1=Result
MemWrite  output  1  data memory write enable
IRWrite  output  1  instruction/OldPC register enable
ResultSrc  output  2  00=ALUOut, 01=Data, 10=ALUResult
ALUSrcA  output  2  00=PC, 01=OldPC, 10=RD1
ALUSrcB  output  2  00=RD2, 01=ImmExt, 10=constant 4
ImmSrc  output  3  000=I, 001=S, 010=B, 011=J
ALUControl  output  CONTROL_WIDTH  ALU operation
RegWrite  output  1  register file write enable
Retire  output  1  one-cycle pulse on the final cycle of each completed instruction
Illegal  output  1  one-cycle pulse when an unsupported encoding is decoded

Behaviour:
- Reset: synchronous, active-high. While rst=1, all enables (PCWrite, MemWrite, IRWrite, RegWrite, Retire, Illegal) are forced to 0. On the first edge with rst=1 the state becomes FETCH. A reset asserted mid-instruction abandons it; no writes occur.
- Outputs are Moore (decoded from the current state). Exceptions: PCWrite in BRANCH depends on EQ; ImmSrc is decoded combinationally from op in every state. Unlisted outputs are 0, and ALUControl is ADD unless stated.
- FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ADD, ResultSrc=10, PCWrite=1. Next state is DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=01, ADD (precomputes the branch/jal target). Next state by op:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - otherwise illegal
- DECODE legality checks:
  - Loads/stores require funct3=010.
  - R and I types require funct3 in {000, 100, 110, 111}.
  - R type with funct7b5=1 is legal only for funct3=000 (sub).
  - Branches require funct3 in {000, 001}.
  - Anything else is illegal. Illegal asserts for that DECODE cycle, and the next state is FETCH (or HALT, see Optional Feature).
- MEMADR: ALUSrcA=10, ALUSrcB=01, ADD. Next state is MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: ResultSrc=00, AdrSrc=1. Next state is MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, Retire=1. Next state is FETCH.
- MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1, Retire=1. Next state is FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00. funct3 mapping: 000 -> ADD, or SUB if funct7b5=1; 100 -> XOR; 110 -> OR; 111 -> AND. Next state is ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01. Same mapping as EXECR, except funct7b5 is ignored (000 is always ADD). Next state is ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, Retire=1. Next state is FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=00, SUB, ResultSrc=00, Retire=1. PCWrite = EQ for funct3=000, ~EQ for funct3=001. Next state is FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, ADD (link = OldPC+4), ResultSrc=00, PCWrite=1. Next state is ALUWB.
- Cycle counts from FETCH to FETCH: lw 5; sw, R, I and jal 4; branch 3; illegal 2.
- At most one of MemWrite, RegWrite and IRWrite is high in any cycle.
- Unreachable state encodings return to FETCH on the next edge with all enables 0.

Optional Feature:
Macro ILLEGAL_TRAP_EN.
- Defined: an illegal decode enters HALT. In HALT all enables are 0, Illegal is held at 1, and the FSM stays there until rst.
- Undefined: an illegal decode pulses Illegal for 1 cycle and returns to FETCH (the instruction acts as a NOP, with PC already advanced by 4). No HALT state exists.

Test Plan:
- Reset: hold rst=1 for 3 cycles from an arbitrary state, then release -> next cycle is FETCH with IRWrite=1, PCWrite=1, ALUSrcB=10, ALUControl=000, and no write enable asserted during reset.
- R sub: op=0110011, funct3=000, funct7b5=1 -> EXECR cycle shows ALUControl=001, ALUSrcA=10, ALUSrcB=00; RegWrite=1 exactly once in ALUWB; 4 cycles total.
- lw: op=0000011, funct3=010 -> sequence FETCH, DECODE, MEMADR, MEMREAD (AdrSrc=1), MEMWB (ResultSrc=01, RegWrite=1); Retire pulses once.
- Branches: beq with EQ=1 -> PCWrite=1 in BRANCH with ALUControl=001; beq with EQ=0 -> PCWrite=0; bne with EQ=0 -> PCWrite=1; each completes in 3 cycles.
- jal: op=1101111 -> JAL cycle has PCWrite=1, ALUSrcA=01, ALUSrcB=10; ALUWB has RegWrite=1; ImmSrc=011 throughout.
- Illegal: op=0110011, funct3=001 -> Illegal=1 in DECODE. Without ILLEGAL_TRAP_EN, FETCH follows. With it, the FSM stays in HALT with Illegal=1 and PCWrite=0 for 10 or more cycles, until rst.
